// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - EX/MEM inputs, pipeline control and MEM/WB outputs of mem_wb_stage
interface mem_wb_stage_if;
  logic        stall;
  logic        flush;
  logic        Reg_Write_in;
  logic        Mem_Read;
  logic        Mem_Write;
  logic        Mem_to_Reg_in;
  logic [4:0]  Reg_Dst;
  logic [31:0] Address;
  logic [31:0] Write_Data;
  logic        Reg_Write_wb;
  logic        Mem_to_Reg_wb;
  logic [4:0]  Reg_Dst_wb;
  logic [31:0] Read_Data_wb;
  logic [31:0] ALU_Result_wb;
  logic [31:0] Write_Back_Data;
  logic [31:0] Load_Count;
  logic [31:0] Store_Count;
  logic        Misaligned;

  modport master (
    output stall, flush, Reg_Write_in, Mem_Read, Mem_Write, Mem_to_Reg_in,
           Reg_Dst, Address, Write_Data,
    input  Reg_Write_wb, Mem_to_Reg_wb, Reg_Dst_wb, Read_Data_wb, ALU_Result_wb,
           Write_Back_Data, Load_Count, Store_Count, Misaligned
  );

  modport slave (
    input  stall, flush, Reg_Write_in, Mem_Read, Mem_Write, Mem_to_Reg_in,
           Reg_Dst, Address, Write_Data,
    output Reg_Write_wb, Mem_to_Reg_wb, Reg_Dst_wb, Read_Data_wb, ALU_Result_wb,
           Write_Back_Data, Load_Count, Store_Count, Misaligned
  );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MIPS memory stage with data memory, MEM/WB register and load/store counters
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_wb_stage #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         rst,
  mem_wb_stage_if.slave bus
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   rdata;
  logic          commit;
  logic          misaligned_d;
  logic          do_load;
  logic          do_store;

  logic          reg_write_q, reg_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;
  logic [4:0]    reg_dst_q, reg_dst_d;
  logic [31:0]   read_data_q, read_data_d;
  logic [31:0]   alu_result_q, alu_result_d;
  logic          misaligned_q, misaligned_d2;
  logic [31:0]   load_count_q, load_count_d;
  logic [31:0]   store_count_q, store_count_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.Address[31:AW+2], bus.Address[1:0]};

  assign idx    = bus.Address[AW+1:2];
  assign rdata  = mem_q[idx];
  assign commit = !rst && !bus.flush && !bus.stall;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_d = (bus.Mem_Read || bus.Mem_Write) && (bus.Address[1:0] != 2'b00);
`else
  assign misaligned_d = 1'b0;
`endif

  assign do_load  = bus.Mem_Read && !misaligned_d;
  assign do_store = bus.Mem_Write && !misaligned_d;

  // No reset on the array: contents survive rst and are undefined until written.
  always_ff @(posedge clk) begin
    if (commit && do_store) mem_q[idx] <= bus.Write_Data;
  end

  always_comb begin
    reg_write_d   = reg_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    reg_dst_d     = reg_dst_q;
    read_data_d   = read_data_q;
    alu_result_d  = alu_result_q;
    misaligned_d2 = misaligned_q;
    load_count_d  = load_count_q;
    store_count_d = store_count_q;
    if (bus.flush) begin
      reg_write_d   = 1'b0;
      mem_to_reg_d  = 1'b0;
      reg_dst_d     = 5'd0;
      read_data_d   = 32'd0;
      alu_result_d  = 32'd0;
      misaligned_d2 = 1'b0;
    end else if (!bus.stall) begin
      reg_write_d   = bus.Reg_Write_in && (bus.Reg_Dst != 5'd0);
      mem_to_reg_d  = bus.Mem_to_Reg_in;
      reg_dst_d     = bus.Reg_Dst;
      read_data_d   = do_load ? rdata : 32'd0;
      alu_result_d  = bus.Address;
      misaligned_d2 = misaligned_d;
      if (do_load)  load_count_d  = load_count_q + 32'd1;
      if (do_store) store_count_d = store_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      reg_dst_q     <= 5'd0;
      read_data_q   <= 32'd0;
      alu_result_q  <= 32'd0;
      misaligned_q  <= 1'b0;
      load_count_q  <= 32'd0;
      store_count_q <= 32'd0;
    end else begin
      reg_write_q   <= reg_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      reg_dst_q     <= reg_dst_d;
      read_data_q   <= read_data_d;
      alu_result_q  <= alu_result_d;
      misaligned_q  <= misaligned_d2;
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
    end
  end

  assign bus.Reg_Write_wb    = reg_write_q;
  assign bus.Mem_to_Reg_wb   = mem_to_reg_q;
  assign bus.Reg_Dst_wb      = reg_dst_q;
  assign bus.Read_Data_wb    = read_data_q;
  assign bus.ALU_Result_wb   = alu_result_q;
  assign bus.Write_Back_Data = mem_to_reg_q ? read_data_q : alu_result_q;
  assign bus.Load_Count      = load_count_q;
  assign bus.Store_Count     = store_count_q;
  assign bus.Misaligned      = misaligned_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_wb_stage_if bus ();
  mem_wb_stage #(.DEPTH(1024)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic [4:0]  dst;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] lc;
    logic [31:0] sc;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        st;
  logic [31:0] mmem [1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic r, input logic stl, input logic fl, input logic rwi,
                     input logic mr, input logic mw, input logic mtr, input logic [4:0] dst,
                     input logic [31:0] addr, input logic [31:0] wd);
    logic [9:0]  ix;
    logic        mis;
    logic [31:0] old;
    exp_t        e;
    @(negedge clk);
    rst = r;
    bus.stall = stl;  bus.flush = fl;  bus.Reg_Write_in = rwi;
    bus.Mem_Read = mr;  bus.Mem_Write = mw;  bus.Mem_to_Reg_in = mtr;
    bus.Reg_Dst = dst;  bus.Address = addr;  bus.Write_Data = wd;
    ix = addr[11:2];
`ifdef MEM_ALIGN_CHECK_EN
    mis = (mr || mw) && (addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (r) begin
      st = '0;
    end else if (fl) begin
      st.rw = 0; st.mtr = 0; st.dst = 0; st.rd = 0; st.alu = 0; st.mis = 0;
    end else if (!stl) begin
      old    = mmem[ix];
      st.rw  = rwi && (dst != 0);
      st.mtr = mtr;
      st.dst = dst;
      st.rd  = (mr && !mis) ? old : 32'd0;
      st.alu = addr;
      st.mis = mis;
      if (mw && !mis) mmem[ix] = wd;
      if (mr && !mis) st.lc = st.lc + 1;
      if (mw && !mis) st.sc = st.sc + 1;
    end
    sb_q.push_back(st);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("reg_write_wb", {31'd0, bus.Reg_Write_wb}, {31'd0, e.rw});
    chk("mem_to_reg_wb", {31'd0, bus.Mem_to_Reg_wb}, {31'd0, e.mtr});
    chk("reg_dst_wb", {27'd0, bus.Reg_Dst_wb}, {27'd0, e.dst});
    chk("read_data_wb", bus.Read_Data_wb, e.rd);
    chk("alu_result_wb", bus.ALU_Result_wb, e.alu);
    chk("write_back_data", bus.Write_Back_Data, e.mtr ? e.rd : e.alu);
    chk("load_count", bus.Load_Count, e.lc);
    chk("store_count", bus.Store_Count, e.sc);
    chk("misaligned", {31'd0, bus.Misaligned}, {31'd0, e.mis});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    st    = '0;
    for (int i = 0; i < 1024; i++) mmem[i] = 32'hx;
    rst = 1'b1;
    bus.stall = 0; bus.flush = 0; bus.Reg_Write_in = 0; bus.Mem_Read = 0;
    bus.Mem_Write = 0; bus.Mem_to_Reg_in = 0; bus.Reg_Dst = 0;
    bus.Address = 0; bus.Write_Data = 0;

    // reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 5, 32'h4, 0);

    // store then load
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF);
    cyc(0, 0, 0, 1, 1, 0, 1, 5, 32'h10, 0);

    // read-before-write
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 32'h20, 32'h11111111);
    cyc(0, 0, 0, 1, 1, 1, 1, 6, 32'h20, 32'h22222222);
    cyc(0, 0, 0, 1, 1, 0, 1, 6, 32'h20, 0);

    // stall suppresses store and holds outputs; flush+stall gives a bubble
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 32'h40, 32'h0000AAAA);
    cyc(0, 0, 0, 1, 1, 0, 1, 7, 32'h10, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 32'h40, 32'h5);
    cyc(0, 1, 0, 1, 1, 0, 0, 9, 32'h20, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, 7, 32'h40, 0);
    cyc(0, 1, 1, 1, 1, 1, 1, 8, 32'h40, 32'h6);
    cyc(0, 0, 0, 1, 1, 0, 1, 7, 32'h40, 0);

    // zero-register guard and address wrap
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 32'h1234, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 32'h1000, 32'h00000077);
    cyc(0, 0, 0, 1, 1, 0, 1, 3, 32'h0, 0);

    // alignment: 0x42 store writes word 0x10 only without the check
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 32'h42, 32'h00000099);
    cyc(0, 0, 0, 1, 1, 0, 1, 4, 32'h40, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, 4, 32'h43, 0);

    // randomised traffic over a prefilled window
    for (int i = 0; i < 16; i++)
      cyc(0, 0, 0, 0, 0, 1, 0, 0, 32'h100 + 32'(i * 4), $urandom);
    for (int i = 0; i < 60; i++) begin
      automatic int r = $urandom_range(0, 9);
      cyc(0, r == 0, r == 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          5'($urandom), 32'h100 + 32'($urandom_range(0, 63)), $urandom);
    end

    // reset with a store in flight leaves memory untouched
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 32'h8, 32'h00000055);
    cyc(1, 0, 0, 1, 0, 1, 0, 2, 32'h8, 32'h00001234);
    cyc(0, 0, 0, 1, 1, 0, 1, 2, 32'h8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline. It consumes the EX/MEM register outputs, performs word loads and stores on an internal data memory, and registers results toward write-back. It also provides the write-back mux output, stall and flush control, and committed load/store counters.

Parameters:
DEPTH, 1024, data memory depth in 32-bit words; must be a power of two.
AW, $clog2(DEPTH), word-index width, derived and not overridden.

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold the MEM/WB register and suppress the store
flush  input  1  insert a bubble into MEM/WB and suppress the store
Reg_Write_in  input  1  register-write control from EX/MEM
Mem_Read  input  1  load enable
Mem_Write  input  1  store enable
Mem_to_Reg_in  input  1  write-back source select (1 = memory)
Reg_Dst  input  5  destination register
Address  input  32  byte address, or ALU result passed through
Write_Data  input  32  store data
Reg_Write_wb  output  1  registered register-write
Mem_to_Reg_wb  output  1  registered source select
Reg_Dst_wb  output  5  registered destination
Read_Data_wb  output  32  registered load data
ALU_Result_wb  output  32  registered Address
Write_Back_Data  output  32  combinational: Mem_to_Reg_wb ? Read_Data_wb : ALU_Result_wb
Load_Count  output  32  committed loads
Store_Count  output  32  committed stores
Misaligned  output  1  registered misaligned-access flag (optional feature)

Behaviour:
- Memory: DEPTH x 32 array, word index = Address[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4. Contents are not affected by rst and are undefined until written.
- Commit condition for an access in a cycle: !rst && !flush && !stall.
- Store: on the rising edge with Mem_Write and commit, mem[idx] <= Write_Data.
- Load: mem[idx] is read combinationally and captured into Read_Data_wb on the edge. If Mem_Read=0, Read_Data_wb <= 0.
- Mem_Read and Mem_Write both high at the same index: the load returns the old data (read-before-write); the store still commits.
- Latency: inputs sampled at edge N appear on the *_wb outputs immediately after edge N (1 cycle).
- Zero-register guard: if Reg_Dst == 0, Reg_Write_wb <= 0 regardless of Reg_Write_in.
- Priority is rst > flush > stall > normal.
  - rst: all *_wb outputs 0, Load_Count=0, Store_Count=0, Misaligned=0, store suppressed. This includes a store in flight in the reset cycle.
  - flush: all *_wb registers <= 0 (bubble), store suppressed, counters unchanged.
  - stall: all *_wb registers hold their value, store suppressed, counters unchanged. The load result is not recaptured.
- Counters: +1 on each committed Mem_Read (Load_Count) or Mem_Write (Store_Count). Both increment in the same cycle when both are high. They wrap from 0xFFFFFFFF to 0.
- Reset values: every output is 0. Write_Back_Data is therefore also 0.

Optional Feature:
Macro MEM_ALIGN_CHECK_EN.
- Defined: an access (Mem_Read or Mem_Write) with Address[1:0] != 0 is misaligned.
  - A misaligned store is suppressed and not counted.
  - A misaligned load gives Read_Data_wb <= 0 and is not counted.
  - Misaligned <= 1 for that cycle's register update. Misaligned follows stall/flush/rst like the other *_wb registers.
- Undefined: Address[1:0] are ignored, accesses proceed as word accesses, and Misaligned is tied to 0.

Test Plan:
- Store then load: store 0xDEADBEEF at Address 0x10, then load 0x10 with Mem_to_Reg_in=1 → Read_Data_wb=0xDEADBEEF and Write_Back_Data=0xDEADBEEF one cycle later; Store_Count=1, Load_Count=1.
- Read-before-write: mem[0x20]=0x11111111; same-cycle load+store of 0x22222222 at 0x20 → Read_Data_wb=0x11111111; a following load returns 0x22222222.
- Stall/flush: stall during a store of 0x5 at 0x40 → mem unchanged and *_wb held. Assert flush and stall together → all *_wb are 0 and counters unchanged.
- Zero register and wrap: Reg_Write_in=1, Reg_Dst=0 → Reg_Write_wb=0. With DEPTH=1024, a store at 0x1000 followed by a load at 0x0 returns the stored value.
- Reset mid-operation: rst with Mem_Write=1 and Address=0x8 → mem[2] unchanged, all outputs and counters 0 on the next cycle.
- MEM_ALIGN_CHECK_EN defined: store at 0x42 → no write, Misaligned=1, Store_Count unchanged. Without the macro, the same store writes mem[0x10] and Misaligned=0.
